// File: rtl/cache_ctrl_fsm_n_if.sv
// Bus bundle for the N-way cache controller: CPU request, tag/status
// inputs, array write strobes and the writeback/refill channels.
interface cache_ctrl_fsm_n_if #(
  parameter int WAYS       = 4,
  parameter int LINE_BEATS = 4
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [2*WAYS-1:0] st_bits;
  logic [WAYS-2:0]   plru_state;
  logic [WAY_W-1:0]  acc_way;
  logic              st_we;
  logic [1:0]        st_new;
  logic              plru_we;
  logic [WAYS-2:0]   plru_new;
  logic              aw_valid;
  logic              aw_ready;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic              b_valid;
  logic              ar_valid;
  logic              ar_ready;
  logic              r_valid;
  logic [BEAT_W-1:0] beat_idx;
  logic              line_we;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    input  req_valid, req_we, hit, hit_way, st_bits, plru_state,
    input  aw_ready, w_ready, b_valid, ar_ready, r_valid, resp_ready,
    output req_ready, acc_way, st_we, st_new, plru_we, plru_new,
    output aw_valid, w_valid, w_last, ar_valid, beat_idx, line_we,
    output resp_valid
  );

  modport slave (
    output req_valid, req_we, hit, hit_way, st_bits, plru_state,
    output aw_ready, w_ready, b_valid, ar_ready, r_valid, resp_ready,
    input  req_ready, acc_way, st_we, st_new, plru_we, plru_new,
    input  aw_valid, w_valid, w_last, ar_valid, beat_idx, line_we,
    input  resp_valid
  );
endinterface

// File: rtl/cache_ctrl_fsm_n.sv
// N-way cache controller FSM: hit/miss sequencing, invalid-first/PLRU
// victim choice, dirty writeback and line refill.
module cache_ctrl_fsm_n #(
  parameter int WAYS       = 4,
  parameter int LINE_BEATS = 4
) (
  input logic                clk,
  input logic                rst_n,
  cache_ctrl_fsm_n_if.master bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WB_AW, WB_W, WB_B, RF_AR, RF_R, UPDATE, RESP
  } state_t;

  state_t            state;
  logic              we_q;
  logic              req_ready;
  logic [WAY_W-1:0]  acc_way;
  logic              st_we;
  logic [1:0]        st_new;
  logic              plru_we;
  logic [WAYS-2:0]   plru_new;
  logic              aw_valid;
  logic              w_valid;
  logic              w_last;
  logic              ar_valid;
  logic [BEAT_W-1:0] beat_idx;
  logic              resp_valid;
  logic [WAY_W-1:0]  vic;
  logic              vic_dirty;

  function automatic logic tree_bit(
    input logic [WAYS-2:0] tree,
    input int              node
  );
    logic b;
    b = 1'b0;
    for (int n = 0; n < WAYS - 1; n++)
      if (n == node) b = tree[n];
    return b;
  endfunction

  function automatic logic [WAY_W-1:0] victim(
    input logic [2*WAYS-1:0] st,
    input logic [WAYS-2:0]   tree
  );
    logic             found;
    logic [WAY_W-1:0] v;
    int               node;
    found = 1'b0;
    v     = '0;
    node  = 0;
    for (int w = 0; w < WAYS; w++)
      if (!found && !st[2*w]) begin
        v     = WAY_W'(w);
        found = 1'b1;
      end
    if (!found) begin
      for (int l = 0; l < WAY_W; l++)
        node = tree_bit(tree, node) ? 2*node + 2 : 2*node + 1;
      v = WAY_W'(node - (WAYS - 1));
    end
    return v;
  endfunction

  // Every node on the way's path is pointed at the opposite subtree.
  function automatic logic [WAYS-2:0] plru_upd(
    input logic [WAYS-2:0]  tree,
    input logic [WAY_W-1:0] way
  );
    logic [WAYS-2:0] t;
    logic            b;
    int              node;
    t    = tree;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) t[n] = ~b;
      node = b ? 2*node + 2 : 2*node + 1;
    end
    return t;
  endfunction

  assign vic = victim(bus.st_bits, bus.plru_state);

  always_comb begin
    vic_dirty = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (WAY_W'(w) == vic)
        vic_dirty = bus.st_bits[2*w+1] & bus.st_bits[2*w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      acc_way    <= '0;
      st_we      <= 1'b0;
      st_new     <= 2'b00;
      plru_we    <= 1'b0;
      plru_new   <= '0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      w_last     <= 1'b0;
      ar_valid   <= 1'b0;
      beat_idx   <= '0;
      resp_valid <= 1'b0;
    end else begin
      st_we   <= 1'b0;
      plru_we <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q      <= bus.req_we;
          req_ready <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: if (bus.hit) begin
          acc_way    <= bus.hit_way;
          plru_we    <= 1'b1;
          plru_new   <= plru_upd(bus.plru_state, bus.hit_way);
          st_we      <= we_q;
          st_new     <= 2'b11;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else begin
          acc_way <= vic;
          if (vic_dirty) begin
            aw_valid <= 1'b1;
            state    <= WB_AW;
          end else begin
            ar_valid <= 1'b1;
            state    <= RF_AR;
          end
        end
        WB_AW: if (bus.aw_ready) begin
          aw_valid <= 1'b0;
          w_valid  <= 1'b1;
          w_last   <= (LAST == '0);
          state    <= WB_W;
        end
        WB_W: if (bus.w_ready) begin
          if (beat_idx == LAST) begin
            w_valid  <= 1'b0;
            w_last   <= 1'b0;
            beat_idx <= '0;
            state    <= WB_B;
          end else begin
            beat_idx <= beat_idx + BEAT_W'(1);
            w_last   <= ((beat_idx + BEAT_W'(1)) == LAST);
          end
        end
        WB_B: if (bus.b_valid) begin
          ar_valid <= 1'b1;
          state    <= RF_AR;
        end
        RF_AR: if (bus.ar_ready) begin
          ar_valid <= 1'b0;
          state    <= RF_R;
        end
        RF_R: if (bus.r_valid) begin
          if (beat_idx == LAST) begin
            beat_idx <= '0;
            st_we    <= 1'b1;
            st_new   <= {we_q, 1'b1};
            plru_we  <= 1'b1;
            plru_new <= plru_upd(bus.plru_state, acc_way);
            state    <= UPDATE;
          end else begin
            beat_idx <= beat_idx + BEAT_W'(1);
          end
        end
        UPDATE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.acc_way    = acc_way;
  assign bus.st_we      = st_we;
  assign bus.st_new     = st_new;
  assign bus.plru_we    = plru_we;
  assign bus.plru_new   = plru_new;
  assign bus.aw_valid   = aw_valid;
  assign bus.w_valid    = w_valid;
  assign bus.w_last     = w_last;
  assign bus.ar_valid   = ar_valid;
  assign bus.beat_idx   = beat_idx;
  assign bus.line_we    = (state == RF_R) && bus.r_valid;
  assign bus.resp_valid = resp_valid;
endmodule

// File: tb/tb_cache_ctrl_fsm_n.sv
// Bench for cache_ctrl_fsm_n: vector table with a scoreboard queue
// on a 4-way/4-beat instance, plus reset and 8-way hand sequences.
module tb_cache_ctrl_fsm_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_fsm_n_if #(.WAYS(4), .LINE_BEATS(4)) b4();
  cache_ctrl_fsm_n_if #(.WAYS(8), .LINE_BEATS(1)) b8();

  cache_ctrl_fsm_n #(.WAYS(4), .LINE_BEATS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.master)
  );
  cache_ctrl_fsm_n #(.WAYS(8), .LINE_BEATS(1)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic       hit;
    logic [1:0] hit_way;
    logic [7:0] st;
    logic [2:0] plru;
    int         aws;
    int         ws;
    int         ars;
    logic [1:0] e_way;
    int         e_aw;
    int         e_w;
    int         e_lw;
    int         e_stwe;
    logic [1:0] e_stnew;
    logic [2:0] e_plru;
    int         e_lat;
  } vec_t;

  vec_t vt[7];
  vec_t sb[$];

  task automatic idle_inputs();
    b4.req_valid = 0; b4.req_we = 0; b4.hit = 0; b4.hit_way = '0;
    b4.st_bits = '0; b4.plru_state = '0; b4.aw_ready = 0;
    b4.w_ready = 0; b4.b_valid = 0; b4.ar_ready = 0;
    b4.r_valid = 0; b4.resp_ready = 0;
    b8.req_valid = 0; b8.req_we = 0; b8.hit = 0; b8.hit_way = '0;
    b8.st_bits = '0; b8.plru_state = '0; b8.aw_ready = 0;
    b8.w_ready = 0; b8.b_valid = 0; b8.ar_ready = 0;
    b8.r_valid = 0; b8.resp_ready = 0;
  endtask

  initial begin
    vec_t e;
    int aws, ws, ars, cyc, n_aw, n_w, n_lw, n_st, n_pw, lat, n_stp;
    bit started, done, seq_ok, hold_aw, hold_w, hold_ar, fired;
    logic [1:0] o_way, o_stnew;
    logic [2:0] o_plru;
    logic [6:0] o8_plru;
    logic [2:0] o8_way;
    logic [1:0] hold_beat;

    vt[0] = '{0, 1, 2'd2, 8'h55, 3'b000, 0, 0, 0,
              2'd2, 0, 0, 0, 0, 2'b00, 3'b100, 2};
    vt[1] = '{1, 1, 2'd1, 8'h55, 3'b111, 0, 0, 0,
              2'd1, 0, 0, 0, 1, 2'b11, 3'b101, 2};
    vt[2] = '{1, 0, 2'd0, 8'b01010001, 3'b000, 0, 0, 0,
              2'd1, 0, 0, 4, 1, 2'b11, 3'b001, 8};
    vt[3] = '{0, 0, 2'd0, 8'b01010111, 3'b000, 0, 0, 0,
              2'd0, 1, 4, 4, 1, 2'b01, 3'b011, 14};
    vt[4] = '{0, 0, 2'd0, 8'b11010101, 3'b111, 2, 5, 5,
              2'd3, 1, 4, 4, 1, 2'b01, 3'b010, 26};
    vt[5] = '{0, 0, 2'd0, 8'h55, 3'b110, 0, 0, 1,
              2'd1, 0, 0, 4, 1, 2'b01, 3'b101, 9};
    vt[6] = '{1, 0, 2'd0, 8'b00001101, 3'b111, 0, 0, 0,
              2'd2, 0, 0, 4, 1, 2'b11, 3'b110, 8};

    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst4 req_ready", 32'(b4.req_ready), 1);
    chk("rst4 outputs",
        32'({b4.acc_way, b4.st_we, b4.st_new, b4.plru_we, b4.plru_new,
             b4.aw_valid, b4.w_valid, b4.w_last, b4.ar_valid,
             b4.beat_idx, b4.line_we, b4.resp_valid}), 0);
    chk("rst8 req_ready", 32'(b8.req_ready), 1);
    chk("rst8 outputs",
        32'({b8.acc_way, b8.st_we, b8.plru_we, b8.plru_new,
             b8.beat_idx, b8.resp_valid}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sb.push_back(vt[i]);
      b4.req_valid = 1; b4.req_we = vt[i].we; b4.hit = vt[i].hit;
      b4.hit_way = vt[i].hit_way; b4.st_bits = vt[i].st;
      b4.plru_state = vt[i].plru; b4.r_valid = 1; b4.b_valid = 1;
      b4.resp_ready = 1;
      aws = vt[i].aws; ws = vt[i].ws; ars = vt[i].ars;
      cyc = 0; n_aw = 0; n_w = 0; n_lw = 0; n_st = 0; n_pw = 0;
      lat = -1; started = 0; done = 0; seq_ok = 1;
      hold_aw = 0; hold_w = 0; hold_ar = 0; hold_beat = '0;
      o_way = '0; o_stnew = '0; o_plru = '0;
      for (int c = 0; c < 200 && !done; c++) begin
        if (c > 0) @(negedge clk);
        if (started) begin
          cyc++;
          b4.req_valid = 0;
        end
        if (b4.st_we) begin n_st++; o_stnew = b4.st_new; end
        if (b4.plru_we) begin
          n_pw++; o_plru = b4.plru_new; o_way = b4.acc_way;
        end
        if (b4.line_we) begin
          if (b4.beat_idx != 2'(n_lw) || b4.acc_way != vt[i].e_way)
            seq_ok = 0;
          n_lw++;
        end
        if (hold_aw && !b4.aw_valid) seq_ok = 0;
        if (hold_ar && !b4.ar_valid) seq_ok = 0;
        if (hold_w && (!b4.w_valid || b4.beat_idx != hold_beat))
          seq_ok = 0;
        if (b4.aw_valid && aws > 0) begin
          b4.aw_ready = 0; aws--;
        end else b4.aw_ready = b4.aw_valid;
        if (b4.w_valid && n_w == 1 && ws > 0) begin
          b4.w_ready = 0; ws--;
        end else b4.w_ready = b4.w_valid;
        if (b4.ar_valid && ars > 0) begin
          b4.ar_ready = 0; ars--;
        end else b4.ar_ready = b4.ar_valid;
        hold_aw = b4.aw_valid && !b4.aw_ready;
        hold_ar = b4.ar_valid && !b4.ar_ready;
        hold_w = b4.w_valid && !b4.w_ready;
        hold_beat = b4.beat_idx;
        if (b4.aw_valid && b4.aw_ready) n_aw++;
        if (b4.w_valid && b4.w_ready) begin
          if (b4.beat_idx != 2'(n_w) || b4.w_last != (n_w == 3))
            seq_ok = 0;
          n_w++;
        end
        if (b4.resp_valid) begin done = 1; lat = cyc; end
        if (!started && b4.req_valid && b4.req_ready) started = 1;
      end
      chk($sformatf("v%0d completed", i), 32'(done), 1);
      @(negedge clk);
      chk($sformatf("v%0d req_ready after", i), 32'(b4.req_ready), 1);
      b4.aw_ready = 0; b4.w_ready = 0; b4.ar_ready = 0;
      b4.resp_ready = 0; b4.r_valid = 0; b4.b_valid = 0;
      e = sb.pop_front();
      chk($sformatf("v%0d acc_way", i), 32'(o_way), 32'(e.e_way));
      chk($sformatf("v%0d aw count", i), n_aw, e.e_aw);
      chk($sformatf("v%0d w beats", i), n_w, e.e_w);
      chk($sformatf("v%0d line_we", i), n_lw, e.e_lw);
      chk($sformatf("v%0d st_we", i), n_st, e.e_stwe);
      chk($sformatf("v%0d st_new", i), 32'(o_stnew), 32'(e.e_stnew));
      chk($sformatf("v%0d plru_we", i), n_pw, 1);
      chk($sformatf("v%0d plru_new", i), 32'(o_plru), 32'(e.e_plru));
      chk($sformatf("v%0d latency", i), lat, e.e_lat);
      chk($sformatf("v%0d beat order/hold", i), 32'(seq_ok), 1);
    end

    // Reset asserted while refill beat 2 is on the bus.
    @(negedge clk);
    b4.req_valid = 1; b4.req_we = 1; b4.hit = 0; b4.st_bits = 8'h55;
    b4.plru_state = 3'b000; b4.aw_ready = 1; b4.w_ready = 1;
    b4.ar_ready = 1; b4.b_valid = 1; b4.r_valid = 1; b4.resp_ready = 1;
    n_stp = 0; fired = 0;
    for (int c = 0; c < 50 && !fired; c++) begin
      @(negedge clk);
      b4.req_valid = 0;
      if (b4.st_we) n_stp++;
      if (b4.line_we && b4.beat_idx == 2'd2) begin
        rst_n = 1'b0;
        fired = 1;
      end
    end
    chk("rst_mid reached beat 2", 32'(fired), 1);
    #1;
    chk("rst_mid line_we", 32'(b4.line_we), 0);
    @(negedge clk);
    chk("rst_mid req_ready", 32'(b4.req_ready), 1);
    chk("rst_mid outputs",
        32'({b4.st_we, b4.plru_we, b4.ar_valid, b4.aw_valid,
             b4.w_valid, b4.beat_idx, b4.line_we, b4.resp_valid}), 0);
    rst_n = 1'b1;
    b4.r_valid = 0; b4.resp_ready = 0;
    repeat (3) begin
      @(negedge clk);
      if (b4.st_we) n_stp++;
    end
    chk("rst_mid st_we never", n_stp, 0);
    chk("rst_mid idle after", 32'(b4.req_ready), 1);

    // 8-way, single-beat line: PLRU walk to way 0.
    @(negedge clk);
    b8.req_valid = 1; b8.req_we = 0; b8.hit = 0;
    b8.st_bits = 16'h5555; b8.plru_state = 7'b0000000;
    b8.ar_ready = 1; b8.r_valid = 1; b8.resp_ready = 1;
    cyc = 0; n_lw = 0; n_st = 0; n_pw = 0; lat = -1;
    started = 0; done = 0; seq_ok = 1;
    o8_plru = '0; o8_way = '0; o_stnew = '0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (started) begin cyc++; b8.req_valid = 0; end
      if (b8.line_we) begin
        if (b8.beat_idx != 1'b0) seq_ok = 0;
        n_lw++;
      end
      if (b8.st_we) begin n_st++; o_stnew = b8.st_new; end
      if (b8.plru_we) begin
        n_pw++; o8_plru = b8.plru_new; o8_way = b8.acc_way;
      end
      if (b8.aw_valid) seq_ok = 0;
      if (b8.resp_valid) begin done = 1; lat = cyc; end
      if (!started && b8.req_valid && b8.req_ready) started = 1;
    end
    chk("w8 completed", 32'(done), 1);
    chk("w8 acc_way", 32'(o8_way), 0);
    chk("w8 line_we", n_lw, 1);
    chk("w8 plru_new", 32'(o8_plru), 32'(7'b0001011));
    chk("w8 st_new", 32'(o_stnew), 32'(2'b01));
    chk("w8 st_we", n_st, 1);
    chk("w8 latency", lat, 5);
    chk("w8 no writeback/beat", 32'(seq_ok), 1);
    @(negedge clk);
    b8.resp_ready = 0; b8.r_valid = 0; b8.ar_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
